game_turn_controller: RTL and testbench

GAME_TURN_CONTROLLER -- requirements
Module: game_turn_controller

---
 rtl/game_turn_controller.sv | 188 ++++++++++++++++++
 tb/tb_game_turn_controller.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_turn_controller.sv
// Turn sequencer for a multi-player board game: rotates move requests, counts
// illegal retries and per-turn timeouts, and resolves win / draw outcomes.
module game_turn_controller #(
   parameter int unsigned NUM_PLAYERS = 2,
   parameter int unsigned TIMEOUT     = 255,
   parameter int unsigned MAX_ILLEGAL = 3
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   play,
   input  logic                   abort,
   input  logic                   move_done,
   input  logic                   illegal_move,
   input  logic                   win,
   input  logic                   no_space,
   output logic [NUM_PLAYERS-1:0] turn_req,
   output logic [1:0]             active_player,
   output logic                   skip,
   output logic                   game_over,
   output logic [1:0]             winner,
   output logic                   winner_valid,
   output logic                   draw
);

   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      TURN  = 2'b01,
      CHECK = 2'b10,
      DONE  = 2'b11
   } state_t;

   state_t                 state_q, state_d;
   logic [NUM_PLAYERS-1:0] turn_req_q, turn_req_d;
   logic [1:0]             active_q, active_d;
   logic [1:0]             winner_q, winner_d;
   logic [1:0]             retry_q, retry_d;
   logic [2:0]             streak_q, streak_d;
   logic [TW-1:0]          timer_q, timer_d;
   logic                   skip_q, skip_d;
   logic                   game_over_q, game_over_d;
   logic                   winner_valid_q, winner_valid_d;
   logic                   draw_q, draw_d;
   logic                   play_q, play_d;
   logic                   armed_q, armed_d;

   logic       start;
   logic [1:0] next_player;
   logic       skip_now;

   assign start       = play & ~play_q & armed_q;
   assign next_player = (active_q == 2'(NUM_PLAYERS - 1)) ? '0 : active_q + 2'd1;

   always_comb begin
      state_d        = state_q;
      active_d       = active_q;
      winner_d       = winner_q;
      retry_d        = retry_q;
      streak_d       = streak_q;
      timer_d        = timer_q;
      winner_valid_d = winner_valid_q;
      draw_d         = draw_q;
      skip_d         = 1'b0;
      skip_now       = 1'b0;
      play_d         = play;
      // Blocks a start on the first edge after reset so a play level held
      // through reset release is not mistaken for a rising edge.
      armed_d        = 1'b1;

      if (abort) begin
         state_d        = IDLE;
         active_d       = '0;
         winner_d       = '0;
         retry_d        = '0;
         streak_d       = '0;
         timer_d        = '0;
         winner_valid_d = 1'b0;
         draw_d         = 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_d        = TURN;
                  active_d       = '0;
                  winner_d       = '0;
                  retry_d        = '0;
                  streak_d       = '0;
                  timer_d        = '0;
                  winner_valid_d = 1'b0;
                  draw_d         = 1'b0;
               end
            end
            TURN: begin
               if (move_done && !illegal_move) begin
                  state_d = CHECK;
               end else if (move_done) begin
                  if (32'(retry_q) + 32'd1 < MAX_ILLEGAL) begin
                     retry_d = retry_q + 2'd1;
                     timer_d = '0;
                  end else begin
                     skip_now = 1'b1;
                  end
               end else if (TIMEOUT != 0 && timer_q == TW'(TIMEOUT - 1)) begin
                  skip_now = 1'b1;
               end else begin
                  timer_d = timer_q + TW'(1);
               end

               if (skip_now) begin
                  skip_d   = 1'b1;
                  active_d = next_player;
                  retry_d  = '0;
                  timer_d  = '0;
                  streak_d = streak_q + 3'd1;
                  if (32'(streak_q) + 32'd1 == NUM_PLAYERS) begin
                     state_d = DONE;
                     draw_d  = 1'b1;
                  end
               end
            end
            CHECK: begin
               if (win) begin
                  state_d        = DONE;
                  winner_d       = active_q;
                  winner_valid_d = 1'b1;
               end else if (no_space) begin
                  state_d = DONE;
                  draw_d  = 1'b1;
               end else begin
                  state_d  = TURN;
                  active_d = next_player;
                  streak_d = '0;
                  retry_d  = '0;
                  timer_d  = '0;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      game_over_d = (state_d == DONE);
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
         turn_req_d[i] = (state_d == TURN) && (active_d == 2'(i));
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         turn_req_q     <= '0;
         active_q       <= '0;
         winner_q       <= '0;
         retry_q        <= '0;
         streak_q       <= '0;
         timer_q        <= '0;
         skip_q         <= 1'b0;
         game_over_q    <= 1'b0;
         winner_valid_q <= 1'b0;
         draw_q         <= 1'b0;
         play_q         <= 1'b0;
         armed_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         turn_req_q     <= turn_req_d;
         active_q       <= active_d;
         winner_q       <= winner_d;
         retry_q        <= retry_d;
         streak_q       <= streak_d;
         timer_q        <= timer_d;
         skip_q         <= skip_d;
         game_over_q    <= game_over_d;
         winner_valid_q <= winner_valid_d;
         draw_q         <= draw_d;
         play_q         <= play_d;
         armed_q        <= armed_d;
      end
   end

   assign turn_req      = turn_req_q;
   assign active_player = active_q;
   assign skip          = skip_q;
   assign game_over     = game_over_q;
   assign winner        = winner_q;
   assign winner_valid  = winner_valid_q;
   assign draw          = draw_q;

endmodule

// File: tb/tb_game_turn_controller.sv
// Directed bench for game_turn_controller: a 2-player/timeout-4 instance and
// a 3-player/no-timeout instance share stimulus; each scenario checks one of them.
module tb_game_turn_controller;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic play = 1'b0, abort = 1'b0, move_done = 1'b0, illegal_move = 1'b0;
   logic win = 1'b0, no_space = 1'b0;

   logic [1:0] a_turn_req, a_active, a_winner;
   logic       a_skip, a_game_over, a_winner_valid, a_draw;
   logic [2:0] b_turn_req;
   logic [1:0] b_active, b_winner;
   logic       b_skip, b_game_over, b_winner_valid, b_draw;

   int n_cmp = 0;
   int n_err = 0;

   game_turn_controller #(.NUM_PLAYERS(2), .TIMEOUT(4), .MAX_ILLEGAL(3)) dut_a (
      .clock(clock), .reset(reset), .play(play), .abort(abort),
      .move_done(move_done), .illegal_move(illegal_move), .win(win), .no_space(no_space),
      .turn_req(a_turn_req), .active_player(a_active), .skip(a_skip),
      .game_over(a_game_over), .winner(a_winner), .winner_valid(a_winner_valid), .draw(a_draw)
   );

   game_turn_controller #(.NUM_PLAYERS(3), .TIMEOUT(0), .MAX_ILLEGAL(3)) dut_b (
      .clock(clock), .reset(reset), .play(play), .abort(abort),
      .move_done(move_done), .illegal_move(illegal_move), .win(win), .no_space(no_space),
      .turn_req(b_turn_req), .active_player(b_active), .skip(b_skip),
      .game_over(b_game_over), .winner(b_winner), .winner_valid(b_winner_valid), .draw(b_draw)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic start_game();
      move_done = 1'b0; illegal_move = 1'b0; win = 1'b0; no_space = 1'b0;
      abort = 1'b1; step();
      abort = 1'b0; play = 1'b0; step();
      play = 1'b1; step();
   endtask

   task automatic test_reset();
      #3 reset = 1'b0;
      #1;
      n_cmp++;
      if ({a_turn_req, a_active, a_skip, a_game_over, a_winner, a_winner_valid, a_draw} !== 10'b0) begin
         n_err++;
         $display("FAIL reset_outputs got %b exp 0",
                  {a_turn_req, a_active, a_skip, a_game_over, a_winner, a_winner_valid, a_draw});
      end
      step(); step();
      #2 reset = 1'b1;
      step(); step();
      n_cmp++;
      if ({a_turn_req, a_game_over} !== 3'b000) begin
         n_err++; $display("FAIL reset_idle got %b exp 000", {a_turn_req, a_game_over});
      end
   endtask

   task automatic test_win_game();
      start_game();
      n_cmp++;
      if ({a_turn_req, a_active} !== 4'b01_00) begin
         n_err++; $display("FAIL win_start got %b exp 0100", {a_turn_req, a_active});
      end
      move_done = 1'b1; step();
      n_cmp++;
      if (a_turn_req !== 2'b00) begin
         n_err++; $display("FAIL win_check1_req got %b exp 00", a_turn_req);
      end
      move_done = 1'b0; step();
      n_cmp++;
      if ({a_turn_req, a_active} !== 4'b10_01) begin
         n_err++; $display("FAIL win_p1_turn got %b exp 1001", {a_turn_req, a_active});
      end
      move_done = 1'b1; step();
      move_done = 1'b0; step();
      n_cmp++;
      if ({a_turn_req, a_active} !== 4'b01_00) begin
         n_err++; $display("FAIL win_p0_turn got %b exp 0100", {a_turn_req, a_active});
      end
      move_done = 1'b1; step();
      move_done = 1'b0; win = 1'b1; step();
      win = 1'b0;
      n_cmp++;
      if ({a_game_over, a_winner, a_winner_valid, a_draw, a_turn_req} !== 7'b1_00_1_0_00) begin
         n_err++; $display("FAIL win_done got %b exp 1001000",
                           {a_game_over, a_winner, a_winner_valid, a_draw, a_turn_req});
      end
      step(); step();
      n_cmp++;
      if ({a_game_over, a_winner, a_winner_valid, a_draw} !== 5'b1_00_1_0) begin
         n_err++; $display("FAIL win_hold got %b exp 10010",
                           {a_game_over, a_winner, a_winner_valid, a_draw});
      end
   endtask

   task automatic test_illegal_skip();
      start_game();
      move_done = 1'b1; illegal_move = 1'b1;
      step(); step();
      n_cmp++;
      if ({b_skip, b_active, b_turn_req} !== 6'b0_00_001) begin
         n_err++; $display("FAIL illegal_retry got %b exp 000001", {b_skip, b_active, b_turn_req});
      end
      step();
      n_cmp++;
      if ({b_skip, b_active, b_turn_req} !== 6'b1_01_010) begin
         n_err++; $display("FAIL illegal_skip got %b exp 101010", {b_skip, b_active, b_turn_req});
      end
      move_done = 1'b0; illegal_move = 1'b0; step();
      n_cmp++;
      if ({b_skip, b_active, b_turn_req} !== 6'b0_01_010) begin
         n_err++; $display("FAIL illegal_pulse got %b exp 001010", {b_skip, b_active, b_turn_req});
      end
   endtask

   task automatic test_timeout_draw();
      start_game();
      step(); step(); step();
      n_cmp++;
      if ({a_skip, a_active} !== 3'b0_00) begin
         n_err++; $display("FAIL timeout_early got %b exp 000", {a_skip, a_active});
      end
      step();
      n_cmp++;
      if ({a_skip, a_active, a_turn_req} !== 5'b1_01_10) begin
         n_err++; $display("FAIL timeout_skip_p0 got %b exp 10110", {a_skip, a_active, a_turn_req});
      end
      step(); step(); step();
      n_cmp++;
      if ({a_skip, a_game_over} !== 2'b00) begin
         n_err++; $display("FAIL timeout_p1_wait got %b exp 00", {a_skip, a_game_over});
      end
      step();
      n_cmp++;
      if ({a_skip, a_game_over, a_draw, a_winner_valid, a_turn_req} !== 6'b1_1_1_0_00) begin
         n_err++; $display("FAIL timeout_draw got %b exp 111000",
                           {a_skip, a_game_over, a_draw, a_winner_valid, a_turn_req});
      end
   endtask

   task automatic test_check_priority();
      start_game();
      move_done = 1'b1; step();
      move_done = 1'b0; win = 1'b1; no_space = 1'b1; step();
      win = 1'b0; no_space = 1'b0;
      n_cmp++;
      if ({a_game_over, a_winner_valid, a_draw} !== 3'b110) begin
         n_err++; $display("FAIL win_over_space got %b exp 110", {a_game_over, a_winner_valid, a_draw});
      end
      start_game();
      move_done = 1'b1; step();
      move_done = 1'b0; no_space = 1'b1; step();
      no_space = 1'b0;
      n_cmp++;
      if ({a_game_over, a_winner_valid, a_draw} !== 3'b101) begin
         n_err++; $display("FAIL no_space_draw got %b exp 101", {a_game_over, a_winner_valid, a_draw});
      end
      start_game();
      step(); step(); step();
      move_done = 1'b1; step();
      move_done = 1'b0;
      n_cmp++;
      if ({a_skip, a_turn_req, a_game_over, a_active} !== 6'b0_00_0_00) begin
         n_err++; $display("FAIL move_beats_timeout got %b exp 000000",
                           {a_skip, a_turn_req, a_game_over, a_active});
      end
      step();
      n_cmp++;
      if ({a_turn_req, a_active} !== 4'b10_01) begin
         n_err++; $display("FAIL check_advance got %b exp 1001", {a_turn_req, a_active});
      end
   endtask

   task automatic test_abort_and_reset();
      start_game();
      move_done = 1'b1; step();
      move_done = 1'b0; step();
      abort = 1'b1; step();
      abort = 1'b0;
      n_cmp++;
      if ({a_turn_req, a_active, a_game_over} !== 5'b0) begin
         n_err++; $display("FAIL abort_idle got %b exp 00000", {a_turn_req, a_active, a_game_over});
      end
      start_game();
      move_done = 1'b1; step();
      move_done = 1'b0; step();
      move_done = 1'b1; step();
      move_done = 1'b0;
      n_cmp++;
      if ({a_active, a_turn_req} !== 4'b01_00) begin
         n_err++; $display("FAIL precheck got %b exp 0100", {a_active, a_turn_req});
      end
      #2 reset = 1'b0;
      #1;
      n_cmp++;
      if ({a_turn_req, a_active, a_skip, a_game_over, a_winner, a_winner_valid, a_draw} !== 10'b0) begin
         n_err++; $display("FAIL async_reset got %b exp 0",
                           {a_turn_req, a_active, a_skip, a_game_over, a_winner, a_winner_valid, a_draw});
      end
      step();
      #2 reset = 1'b1;
      step(); step(); step();
      n_cmp++;
      if ({a_turn_req, a_game_over} !== 3'b000) begin
         n_err++; $display("FAIL play_held_idle got %b exp 000", {a_turn_req, a_game_over});
      end
      play = 1'b0; step();
      play = 1'b1; step();
      n_cmp++;
      if ({a_turn_req, a_active} !== 4'b01_00) begin
         n_err++; $display("FAIL restart got %b exp 0100", {a_turn_req, a_active});
      end
   endtask

   initial begin
      test_reset();
      test_win_game();
      test_illegal_skip();
      test_timeout_draw();
      test_check_priority();
      test_abort_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
